// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
//   over the shared open-drain PS/2 clock/data pins, then reports the outcome
//   as exactly one pulse: device ACK (done), NACK (err_nack) or timeout
//   (err_tmo).
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   tx_data     in   [7:0] byte to send, latched on accept
//   tx_valid    in   send request, accepted when tx_valid && tx_ready
//   tx_ready    out  high only while idle
//   done        out  1-cycle pulse: ACK seen and both lines back high
//   err_nack    out  1-cycle pulse: data line high at the ACK clock edge
//   err_tmo     out  1-cycle pulse: device did not complete in time
//   ps2_clk_i   in   PS/2 clock pin level (asynchronous)
//   ps2_dat_i   in   PS/2 data pin level (asynchronous)
//   ps2_clk_oe  out  1 = pull PS/2 clock low
//   ps2_dat_oe  out  1 = pull PS/2 data low
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned INHIBIT_US = 120,
    parameter int unsigned TIMEOUT_MS = 15,
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       err_nack,
    output logic       err_tmo,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned INH_CYC = (CLK_HZ / 1_000_000) * INHIBIT_US;
    localparam int unsigned TMO_CYC = (CLK_HZ / 1_000) * TIMEOUT_MS;
    localparam int unsigned INH_W   = $clog2(INH_CYC + 1);
    localparam int unsigned TMO_W   = $clog2(TMO_CYC + 1);
    localparam int unsigned FLT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_BITS,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    // -----------------------------------------------------------------------
    // Input conditioning: index 0 = clock line, index 1 = data line.
    // Both lines idle high, so synchronisers and filters reset to 1.
    // -----------------------------------------------------------------------
    logic [1:0]       w_pin;
    logic [1:0]       r_sync_a;
    logic [1:0]       r_sync_b;
    logic [1:0]       r_flt;
    logic [FLT_W-1:0] r_fcnt [2];
    logic             r_flt_clk_q;
    logic             w_fe;
    logic             w_clk;
    logic             w_dat;

    assign w_pin = {ps2_dat_i, ps2_clk_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_a    <= '1;
            r_sync_b    <= '1;
            r_flt       <= '1;
            r_flt_clk_q <= 1'b1;
            for (int unsigned i = 0; i < 2; i++) begin
                r_fcnt[i] <= '0;
            end
        end else begin
            r_sync_a    <= w_pin;
            r_sync_b    <= r_sync_a;
            r_flt_clk_q <= r_flt[0];
            // The filtered level only follows the pin after FILTER_LEN
            // consecutive samples that disagree with it.
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_sync_b[i] == r_flt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FLT_W'(FILTER_LEN - 1)) begin
                    r_flt[i]  <= r_sync_b[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + FLT_W'(1);
                end
            end
        end
    end

    assign w_clk = r_flt[0];
    assign w_dat = r_flt[1];
    assign w_fe  = r_flt_clk_q & ~r_flt[0];

    // -----------------------------------------------------------------------
    // Transmit state machine
    // -----------------------------------------------------------------------
    state_t           r_state;
    logic [7:0]       r_data;
    logic             r_parity;
    logic [3:0]       r_bit_cnt;
    logic [INH_W-1:0] r_inh;
    logic [TMO_W-1:0] r_tmo;
    logic             r_tx_ready;
    logic             r_done;
    logic             r_nack;
    logic             r_tmo_p;
    logic             r_clk_oe;
    logic             r_dat_oe;
    logic             w_bit;

    // Bit to present for the current bit_cnt: data LSB first, parity, stop.
    always_comb begin
        w_bit = 1'b1;
        if (r_bit_cnt < 4'd8) begin
            w_bit = r_data[r_bit_cnt[2:0]];
        end else if (r_bit_cnt == 4'd8) begin
            w_bit = r_parity;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_parity   <= 1'b0;
            r_bit_cnt  <= '0;
            r_inh      <= '0;
            r_tmo      <= '0;
            r_tx_ready <= 1'b1;
            r_done     <= 1'b0;
            r_nack     <= 1'b0;
            r_tmo_p    <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_nack  <= 1'b0;
            r_tmo_p <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_clk_oe   <= 1'b0;
                    r_dat_oe   <= 1'b0;
                    r_tx_ready <= 1'b1;
                    if (tx_valid && r_tx_ready) begin
                        r_data     <= tx_data;
                        r_parity   <= ~^tx_data;
                        r_bit_cnt  <= '0;
                        r_inh      <= INH_W'(INH_CYC - 1);
                        r_clk_oe   <= 1'b1;
                        r_tx_ready <= 1'b0;
                        r_state    <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (r_inh == '0) begin
                        r_dat_oe <= 1'b1;
                        r_state  <= S_REQ;
                    end else begin
                        r_inh <= r_inh - INH_W'(1);
                    end
                end

                S_REQ: begin
                    r_clk_oe <= 1'b0;
                    r_tmo    <= TMO_W'(TMO_CYC);
                    r_state  <= S_BITS;
                end

                S_BITS, S_ACK, S_WAIT_IDLE: begin
                    // Testing for 1 makes the counter land on 0 in the same
                    // cycle the err_tmo pulse and line release appear.
                    if (r_tmo == TMO_W'(1)) begin
                        r_tmo      <= '0;
                        r_clk_oe   <= 1'b0;
                        r_dat_oe   <= 1'b0;
                        r_tmo_p    <= 1'b1;
                        r_tx_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo - TMO_W'(1);
                        case (r_state)
                            S_BITS: begin
                                if (w_fe) begin
                                    r_dat_oe  <= ~w_bit;
                                    r_bit_cnt <= r_bit_cnt + 4'd1;
                                    if (r_bit_cnt == 4'd9) begin
                                        r_state <= S_ACK;
                                    end
                                end
                            end
                            S_ACK: begin
                                if (w_fe) begin
                                    if (!w_dat) begin
                                        r_state <= S_WAIT_IDLE;
                                    end else begin
                                        r_nack     <= 1'b1;
                                        r_tx_ready <= 1'b1;
                                        r_state    <= S_IDLE;
                                    end
                                end
                            end
                            S_WAIT_IDLE: begin
                                if (w_clk && w_dat) begin
                                    r_done     <= 1'b1;
                                    r_tx_ready <= 1'b1;
                                    r_state    <= S_IDLE;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                default: begin
                    r_clk_oe   <= 1'b0;
                    r_dat_oe   <= 1'b0;
                    r_tx_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready   = r_tx_ready;
    assign done       = r_done;
    assign err_nack   = r_nack;
    assign err_tmo    = r_tmo_p;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//   Bench for ps2_host_tx with a behavioural PS/2 device on an open-drain bus.
//   Runs at CLK_HZ = 1 MHz so inhibit = 120 cycles and timeout = 15000 cycles;
//   the device clocks at 12.5 kHz (80-cycle period).
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int unsigned CLK_HZ     = 1_000_000;
    localparam int unsigned INHIBIT_US = 120;
    localparam int unsigned TIMEOUT_MS = 15;
    localparam int unsigned FILTER_LEN = 8;
    localparam int INH_CYC = 120;     // 1 MHz * 120 us
    localparam int TMO_CYC = 15000;   // 1 MHz * 15 ms
    localparam int HALF    = 40;      // half period of the 12.5 kHz device clock

    localparam int K_DONE = 1;
    localparam int K_NACK = 2;
    localparam int K_TMO  = 3;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic [7:0] tx_data  = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, done, err_nack, err_tmo, ps2_clk_oe, ps2_dat_oe;
    logic       ps2_clk_i, ps2_dat_i;
    logic       dev_clk  = 1'b1;
    logic       dev_dat  = 1'b1;
    logic       glitch_n = 1'b1;

    // Open-drain bus: either side can pull a line low.
    assign ps2_clk_i = ~ps2_clk_oe & dev_clk & glitch_n;
    assign ps2_dat_i = ~ps2_dat_oe & dev_dat;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_HZ    (CLK_HZ),
        .INHIBIT_US(INHIBIT_US),
        .TIMEOUT_MS(TIMEOUT_MS),
        .FILTER_LEN(FILTER_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (done),
        .err_nack  (err_nack),
        .err_tmo   (err_tmo),
        .ps2_clk_i (ps2_clk_i),
        .ps2_dat_i (ps2_dat_i),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Scoreboard: expected frame bits and outcomes pushed on request,
    // popped as the device samples bits and as status pulses appear.
    logic exp_bits[$];
    int   exp_res[$];
    int   obs_q[$];      // kind*2 + tx_ready at the pulse
    int   exp_done = 0, exp_nack = 0, exp_tmo = 0;
    int   n_done = 0, n_nack = 0, n_tmo = 0;

    always @(negedge clk) begin
        if (done) begin
            n_done++;
            obs_q.push_back(K_DONE * 2 + int'(tx_ready));
        end
        if (err_nack) begin
            n_nack++;
            obs_q.push_back(K_NACK * 2 + int'(tx_ready));
        end
        if (err_tmo) begin
            n_tmo++;
            obs_q.push_back(K_TMO * 2 + int'(tx_ready));
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fail(input string name, input string what);
        n_total++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic push_frame(input logic [7:0] d, input logic par, input int kind);
        if (kind != K_TMO) begin
            for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
            exp_bits.push_back(par);
            exp_bits.push_back(1'b1);
        end
        exp_res.push_back(kind);
        if (kind == K_DONE) exp_done++;
        if (kind == K_NACK) exp_nack++;
        if (kind == K_TMO)  exp_tmo++;
    endtask

    task automatic request(input logic [7:0] d, input logic par, input int kind);
        int k;
        k = 0;
        @(negedge clk);
        while (!tx_ready && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_req", int'(tx_ready), 1);
        tx_data  = d;
        tx_valid = 1'b1;
        push_frame(d, par, kind);
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    // Follows one accepted byte from inhibit to its status pulse, acting as
    // the device. gl_oe is the data drive expected after the 4th clock.
    task automatic service(input int kind, input bit glitch, input logic gl_oe);
        int   cnt, k, o;
        logic b;
        cnt = 0;
        @(negedge clk);
        check("ready_low_busy", int'(tx_ready), 0);
        k = 0;
        while (!ps2_dat_oe && k < INH_CYC + 50) begin
            if (ps2_clk_oe) cnt++;
            @(negedge clk);
            k++;
        end
        check("inhibit_cycles", cnt, INH_CYC);
        check("req_clk_oe", int'(ps2_clk_oe), 1);
        @(negedge clk);
        check("bits_clk_released", int'(ps2_clk_oe), 0);
        check("start_bit_oe", int'(ps2_dat_oe), 1);

        if (kind == K_TMO) begin
            k = 0;
            while (!err_tmo && k < TMO_CYC + 100) begin
                @(negedge clk);
                k++;
            end
            check("tmo_latency", k, TMO_CYC);
            check("tmo_lines_released", int'({ps2_clk_oe, ps2_dat_oe}), 0);
        end else begin
            repeat (20) @(negedge clk);
            for (int i = 1; i <= 11; i++) begin
                dev_clk = 1'b0;
                repeat (HALF) @(negedge clk);
                if (i <= 10) begin
                    b = ps2_dat_i;
                    if (exp_bits.size() == 0)
                        fail("frame_bit", "got a sampled bit, expected none pending");
                    else
                        check($sformatf("frame_bit%0d", i - 1), int'(b), int'(exp_bits.pop_front()));
                end
                dev_clk = 1'b1;
                if (i == 10 && kind == K_DONE) dev_dat = 1'b0;
                if (glitch && i == 4) begin
                    repeat (10) @(negedge clk);
                    glitch_n = 1'b0;
                    repeat (3) @(negedge clk);
                    glitch_n = 1'b1;
                    repeat (15) @(negedge clk);
                    check("glitch_no_fe", int'(ps2_dat_oe), int'(gl_oe));
                    repeat (HALF - 28) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
            end
            dev_dat = 1'b1;
        end

        k = 0;
        while (!(done || err_nack || err_tmo) && obs_q.size() == 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        #1;
        if (obs_q.size() == 0) begin
            fail("status_pulse", "got no pulse, expected one");
            if (exp_res.size() != 0) void'(exp_res.pop_front());
        end else begin
            o = obs_q.pop_front();
            check("status_kind", o / 2, exp_res.pop_front());
            check("ready_at_status", o % 2, 1);
            check("single_status", obs_q.size(), 0);
        end
    endtask

    task automatic check_totals();
        check("total_done", n_done, exp_done);
        check("total_nack", n_nack, exp_nack);
        check("total_tmo",  n_tmo,  exp_tmo);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;    // odd parity bit the device must see
        int         kind;   // outcome the device model forces
    } vec_t;

    vec_t tbl[6];

    initial begin
        int k;
        tbl[0] = '{8'hED, 1'b1, K_DONE};
        tbl[1] = '{8'h00, 1'b1, K_NACK};
        tbl[2] = '{8'hFF, 1'b1, K_TMO};
        tbl[3] = '{8'h01, 1'b0, K_DONE};
        tbl[4] = '{8'hA5, 1'b1, K_NACK};
        tbl[5] = '{8'h80, 1'b0, K_DONE};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_ready", int'(tx_ready), 1);
        check("rst_pulses", int'({done, err_nack, err_tmo}), 0);
        check("rst_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_ready", int'(tx_ready), 1);
        check("idle_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);

        for (int v = 0; v < 6; v++) begin
            request(tbl[v].data, tbl[v].par, tbl[v].kind);
            service(tbl[v].kind, 1'b0, 1'b0);
        end
        repeat (50) @(negedge clk);
        check_totals();

        // Short clock glitch in BITS: 0x96 has bit3=0 (drive) and bit4=1.
        request(8'h96, 1'b1, K_DONE);
        service(K_DONE, 1'b1, 1'b1);

        // Reset after the 4th falling edge of a 0x55 frame.
        @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        k = 0;
        while (!(ps2_dat_oe && !ps2_clk_oe) && k < INH_CYC + 50) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            dev_clk = 1'b0;
            repeat (i < 4 ? HALF : 20) @(negedge clk);
            if (i < 4) begin
                dev_clk = 1'b1;
                repeat (HALF) @(negedge clk);
            end
        end
        check("pre_reset_dat_oe", int'(ps2_dat_oe), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
        check("async_rst_ready", int'(tx_ready), 1);
        check("async_rst_pulses", int'({done, err_nack, err_tmo}), 0);
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check_totals();
        request(8'hF4, 1'b0, K_DONE);
        service(K_DONE, 1'b0, 1'b0);

        // tx_valid held with new data through a transfer: only accepted
        // once tx_ready returns.
        @(negedge clk);
        k = 0;
        while (!tx_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        tx_data  = 8'hAB;
        tx_valid = 1'b1;
        push_frame(8'hAB, 1'b0, K_DONE);
        @(posedge clk);
        #1 tx_data = 8'h3C;
        push_frame(8'h3C, 1'b1, K_DONE);
        service(K_DONE, 1'b0, 1'b0);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        service(K_DONE, 1'b0, 1'b0);

        repeat (200) @(negedge clk);
        check_totals();
        check("final_ready", int'(tx_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #700000;
        $display("FAIL watchdog: got no end of test, expected finish within 70000 cycles");
        $fatal(1, "simulation time limit reached");
    end

endmodule
